deserializer: RTL and testbench

//   Downstream partner of the serializer: rebuilds parallel words from the serial bit stream.

---
 rtl/deserializer_pkg.sv | 16 +
 rtl/deserializer.sv | 107 ++++++++++
 tb/tb_deserializer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/deserializer_pkg.sv
// Shared serial-link definitions: FSM state encodings, default word width and bit-order constants.
package deserializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Bit-order selectors, common to the serializer and deserializer
  localparam bit ORDER_MSB_FIRST = 1'b1;
  localparam bit ORDER_LSB_FIRST = 1'b0;

endpackage

// File: rtl/deserializer.sv
// Serial-to-parallel word rebuilder with a single valid/ready holding register and overflow flag.
// Optional even-parity frame bit is enabled by defining DESERIALIZER_PARITY_EN.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
  input  logic             in_clock,
  input  logic             in_reset,
  input  logic             in_enable,
  input  logic             in_bit,
  input  logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_overflow,
  output logic             out_parity_error,
  output logic             out_busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);

  state_e           state_q;
  logic [CW-1:0]    bitCount_q;
  logic [WIDTH-1:0] shiftReg_q;
  logic [WIDTH-1:0] shiftReg_d;
  logic [WIDTH-1:0] outData_q;
  logic             outValid_q;
  logic             overflow_q;

  // Word including the bit sampled this edge, so completion can load it directly
  assign shiftReg_d = MSB_FIRST ? {shiftReg_q[WIDTH-2:0], in_bit}
                                : {in_bit, shiftReg_q[WIDTH-1:1]};

`ifdef DESERIALIZER_PARITY_EN
  logic parityErr_q;
`endif

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q    <= IDLE;
      bitCount_q <= '0;
      shiftReg_q <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      overflow_q <= 1'b0;
`ifdef DESERIALIZER_PARITY_EN
      parityErr_q <= 1'b0;
`endif
    end else begin
      overflow_q <= 1'b0;
      if (outValid_q && in_ready) begin
        outValid_q <= 1'b0;
      end
      if (in_enable) begin
        case (state_q)
          IDLE, SHIFT: begin
            shiftReg_q <= shiftReg_d;
            if (bitCount_q == LAST_DATA) begin
`ifdef DESERIALIZER_PARITY_EN
              bitCount_q <= bitCount_q + 1'b1;
              state_q    <= PARITY;
`else
              bitCount_q <= '0;
              state_q    <= IDLE;
              outData_q  <= shiftReg_d;
              outValid_q <= 1'b1;
              overflow_q <= outValid_q && !in_ready;
`endif
            end else begin
              bitCount_q <= bitCount_q + 1'b1;
              state_q    <= SHIFT;
            end
          end
`ifdef DESERIALIZER_PARITY_EN
          PARITY: begin
            // Word is delivered even when the parity check fails
            bitCount_q  <= '0;
            state_q     <= IDLE;
            outData_q   <= shiftReg_q;
            outValid_q  <= 1'b1;
            overflow_q  <= outValid_q && !in_ready;
            parityErr_q <= ^{shiftReg_q, in_bit};
          end
`endif
          default: begin
            bitCount_q <= '0;
            state_q    <= IDLE;
          end
        endcase
      end
    end
  end

  assign out_data     = outData_q;
  assign out_valid    = outValid_q;
  assign out_overflow = overflow_q;
  assign out_busy     = (bitCount_q != '0);

`ifdef DESERIALIZER_PARITY_EN
  assign out_parity_error = parityErr_q;
`else
  assign out_parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer (WIDTH=8, MSB first); parity frames exercised when DESERIALIZER_PARITY_EN is defined.
module tb_deserializer;

  logic       in_clock = 1'b0;
  logic       in_reset;
  logic       in_enable;
  logic       in_bit;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_overflow;
  logic       out_parity_error;
  logic       out_busy;

  int totalChecks = 0;
  int badChecks   = 0;

  // Expected deliveries: {parity error, data}
  logic [8:0] sb[$];
  logic       modelValid;

  deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .in_clock         (in_clock),
    .in_reset         (in_reset),
    .in_enable        (in_enable),
    .in_bit           (in_bit),
    .in_ready         (in_ready),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_overflow     (out_overflow),
    .out_parity_error (out_parity_error),
    .out_busy         (out_busy)
  );

  always #5 in_clock = ~in_clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge
  task automatic applyStimulus(input logic en, input logic b, input logic rdy);
    in_enable = en;
    in_bit    = b;
    in_ready  = rdy;
    @(posedge in_clock);
    #1;
  endtask

  task automatic idleCycle(input logic rdy);
    applyStimulus(1'b0, 1'b0, rdy);
    if (modelValid && rdy) modelValid = 1'b0;
    checkOutput("idleValid", out_valid, modelValid);
    checkOutput("idleOvf", out_overflow, 1'b0);
  endtask

  task automatic sendWord(input logic [7:0] word, input logic rdyAll, input logic rdyLast,
                          input int gapPos, input int gapLen, input logic parFlip);
    int   nBits;
    logic b, rdy, prevValid, expErr;
    logic [8:0] exp;
`ifdef DESERIALIZER_PARITY_EN
    nBits  = 9;
    expErr = parFlip;
`else
    nBits  = 8;
    expErr = 1'b0;
`endif
    for (int i = 0; i < nBits; i++) begin
      if (i < 8) b = word[7-i];
      else       b = (^word) ^ parFlip;
      if (i == gapPos) begin
        for (int g = 0; g < gapLen; g++) begin
          applyStimulus(1'b0, ~b, rdyAll);
          if (modelValid && rdyAll) modelValid = 1'b0;
          checkOutput("gapBusy", out_busy, 1'b1);
          checkOutput("gapValid", out_valid, modelValid);
        end
      end
      rdy       = (i == nBits - 1) ? rdyLast : rdyAll;
      prevValid = modelValid;
      if (i == nBits - 1) sb.push_back({expErr, word});
      applyStimulus(1'b1, b, rdy);
      if (i == nBits - 1) begin
        exp = sb.pop_front();
        checkOutput("data", out_data, exp[7:0]);
        checkOutput("parErr", out_parity_error, exp[8]);
        checkOutput("validDone", out_valid, 1'b1);
        checkOutput("overflow", out_overflow, prevValid && !rdy);
        checkOutput("busyDone", out_busy, 1'b0);
        modelValid = 1'b1;
      end else begin
        if (modelValid && rdy) modelValid = 1'b0;
        checkOutput("validMid", out_valid, modelValid);
        checkOutput("ovfMid", out_overflow, 1'b0);
        checkOutput("busyMid", out_busy, 1'b1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    in_reset   = 1'b1;
    modelValid = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rstData", out_data, 8'h00);
    checkOutput("rstValid", out_valid, 1'b0);
    checkOutput("rstOvf", out_overflow, 1'b0);
    checkOutput("rstPerr", out_parity_error, 1'b0);
    checkOutput("rstBusy", out_busy, 1'b0);
    in_reset = 1'b0;
    idleCycle(1'b1);

    // Basic word, then accept it
    sendWord(8'hAA, 1'b0, 1'b0, -1, 0, 1'b0);
    idleCycle(1'b1);
    idleCycle(1'b1);

    // Gap of three disabled cycles after four bits
    sendWord(8'hB5, 1'b0, 1'b0, 4, 3, 1'b0);
    idleCycle(1'b1);

    // Back-to-back words without acceptance: overflow on the second
    sendWord(8'hAA, 1'b0, 1'b0, -1, 0, 1'b0);
    sendWord(8'h55, 1'b0, 1'b0, -1, 0, 1'b0);
    idleCycle(1'b0);
    checkOutput("held55", out_data, 8'h55);

    // Accept coinciding with completion of the next word
    idleCycle(1'b1);
    sendWord(8'hAA, 1'b0, 1'b0, -1, 0, 1'b0);
    sendWord(8'h3C, 1'b0, 1'b1, -1, 0, 1'b0);
    idleCycle(1'b1);

    // Reset in the middle of a word discards the partial bits
    sendWord(8'h81, 1'b0, 1'b0, -1, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("partBusy", out_busy, 1'b1);
    end
    in_reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    modelValid = 1'b0;
    checkOutput("midRstValid", out_valid, 1'b0);
    checkOutput("midRstBusy", out_busy, 1'b0);
    checkOutput("midRstData", out_data, 8'h00);
    in_reset = 1'b0;
    idleCycle(1'b0);
    sendWord(8'h0F, 1'b0, 1'b0, -1, 0, 1'b0);
    idleCycle(1'b1);

`ifdef DESERIALIZER_PARITY_EN
    sendWord(8'hAA, 1'b0, 1'b1, -1, 0, 1'b1);
    sendWord(8'hAA, 1'b0, 1'b1, -1, 0, 1'b0);
    sendWord(8'h07, 1'b1, 1'b1, 3, 2, 1'b1);
    idleCycle(1'b1);
`endif

    // Random words, random ready, occasional gaps
    for (int r = 0; r < 8; r++) begin
      sendWord(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(1, 7)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    idleCycle(1'b1);

    checkOutput("sbEmpty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
